// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: Frogger game-flow controller.
// Tracks lives, levels, post-collision freeze periods and game-over, and
// drives the round reset used by the frog and car blocks.
// Optional build macro: GAME_FLOW_HISCORE_EN adds the best_level output.
module game_flow_ctrl #(
    parameter int unsigned NUM_LEVELS    = 9,
    parameter int unsigned LEVEL_W       = 4,
    parameter int unsigned NUM_LIVES     = 3,
    parameter int unsigned LIVES_W       = 2,
    parameter int unsigned FREEZE_FRAMES = 30,
    parameter int unsigned FREEZE_W      = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               death_collision,
    input  logic               win_collision,
    output logic               round_reset,
    output logic [LEVEL_W-1:0] current_level,
    output logic [LIVES_W-1:0] lives_left,
    output logic               level_up,
    output logic               game_over,
    output logic [2:0]         state
`ifdef GAME_FLOW_HISCORE_EN
    ,
    output logic [LEVEL_W-1:0] best_level
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        DEATH = 3'd2,
        WIN   = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [LEVEL_W-1:0]  LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0]  FULL_LIVES = LIVES_W'(NUM_LIVES);
    localparam logic [FREEZE_W-1:0] FRZ_LAST   = FREEZE_W'(FREEZE_FRAMES - 1);

    state_t               state_q, state_d;
    logic                 start_q;
    logic                 start_rise;
    logic                 round_reset_q, round_reset_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic                 level_up_q, level_up_d;
    logic                 game_over_q, game_over_d;
    logic [FREEZE_W-1:0]  frz_q, frz_d;
`ifdef GAME_FLOW_HISCORE_EN
    logic [LEVEL_W-1:0]   best_q, best_d;
`endif

    assign start_rise = start & ~start_q;

    // State, counters and registered outputs; start_q is cleared under reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            round_reset_q <= 1'b1;
            level_q       <= '0;
            lives_q       <= FULL_LIVES;
            level_up_q    <= 1'b0;
            game_over_q   <= 1'b0;
            frz_q         <= '0;
`ifdef GAME_FLOW_HISCORE_EN
            best_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            start_q       <= start;
            round_reset_q <= round_reset_d;
            level_q       <= level_d;
            lives_q       <= lives_d;
            level_up_q    <= level_up_d;
            game_over_q   <= game_over_d;
            frz_q         <= frz_d;
`ifdef GAME_FLOW_HISCORE_EN
            best_q        <= best_d;
`endif
        end
    end

    // Next-state, level/lives bookkeeping and freeze counting.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        lives_d    = lives_q;
        frz_d      = frz_q;
        level_up_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = PLAY;
                    level_d = '0;
                    lives_d = FULL_LIVES;
                end
            end
            PLAY: begin
                // Death has priority over a simultaneous win.
                if (death_collision) begin
                    state_d = DEATH;
                    lives_d = lives_q - LIVES_W'(1);
                    frz_d   = '0;
                end else if (win_collision) begin
                    state_d = WIN;
                    frz_d   = '0;
                end
            end
            DEATH: begin
                if (frame_tick) begin
                    if (frz_q == FRZ_LAST) begin
                        state_d = (lives_q == '0) ? OVER : PLAY;
                    end else begin
                        frz_d = frz_q + FREEZE_W'(1);
                    end
                end
            end
            WIN: begin
                if (frame_tick) begin
                    if (frz_q == FRZ_LAST) begin
                        state_d    = PLAY;
                        level_up_d = 1'b1;
                        if (level_q == LAST_LEVEL) begin
                            level_d = '0;
                            lives_d = FULL_LIVES;
                        end else begin
                            level_d = level_q + LEVEL_W'(1);
                        end
                    end else begin
                        frz_d = frz_q + FREEZE_W'(1);
                    end
                end
            end
            OVER: begin
                if (start_rise) begin
                    state_d = PLAY;
                    level_d = '0;
                    lives_d = FULL_LIVES;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they follow the next state.
        round_reset_d = (state_d != PLAY);
        game_over_d   = (state_d == OVER);
    end

`ifdef GAME_FLOW_HISCORE_EN
    // High-score tracking: only moves up on a level advance.
    always_comb begin
        best_d = best_q;
        if (level_up_d && (level_d > best_q)) begin
            best_d = level_d;
        end
    end

    assign best_level = best_q;
`endif

    assign round_reset   = round_reset_q;
    assign current_level = level_q;
    assign lives_left    = lives_q;
    assign level_up      = level_up_q;
    assign game_over     = game_over_q;
    assign state         = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl with default parameters.
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, frame_tick, death_collision, win_collision;
    logic       round_reset;
    logic [3:0] current_level;
    logic [1:0] lives_left;
    logic       level_up, game_over;
    logic [2:0] state;
`ifdef GAME_FLOW_HISCORE_EN
    logic [3:0] best_level;
`endif

    localparam logic [2:0] S_IDLE = 3'd0, S_PLAY = 3'd1, S_DEATH = 3'd2, S_WIN = 3'd3, S_OVER = 3'd4;

    typedef struct packed {
        logic [2:0] st;
        logic       rr;
        logic [3:0] lvl;
        logic [1:0] lives;
        logic       lu;
        logic       go;
    } snap_t;

    snap_t exp_q[$];
    snap_t got, expv;
    int    checks = 0;
    int    errors = 0;

    game_flow_ctrl #(
        .NUM_LEVELS(9), .LEVEL_W(4), .NUM_LIVES(3), .LIVES_W(2),
        .FREEZE_FRAMES(30), .FREEZE_W(5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
        .death_collision(death_collision), .win_collision(win_collision),
        .round_reset(round_reset), .current_level(current_level),
        .lives_left(lives_left), .level_up(level_up), .game_over(game_over),
        .state(state)
`ifdef GAME_FLOW_HISCORE_EN
        , .best_level(best_level)
`endif
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(logic [2:0] st, logic rr, logic [3:0] lvl,
                                 logic [1:0] lv, logic lu, logic go);
        return {st, rr, lvl, lv, lu, go};
    endfunction

    function snap_t obs();
        return {state, round_reset, current_level, lives_left, level_up, game_over};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
        death_collision = 1'b0; win_collision = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; frame_tick = 1'b0;
        death_collision = 1'b0; win_collision = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.push_back(mk(S_IDLE, 1'b1, 4'd0, 2'd3, 1'b0, 1'b0));
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin errors++; $display("FAIL reset_state got=%h exp=%h", got, expv); end
        // start held through reset: edge register was cleared, so this is a rise
        exp_q.push_back(mk(S_PLAY, 1'b0, 4'd0, 2'd3, 1'b0, 1'b0));
        tick();
        start = 1'b0;
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin errors++; $display("FAIL start_held_thru_reset got=%h exp=%h", got, expv); end
    endtask

    task automatic test_start();
        do_reset();
        death_collision = 1'b1;
        exp_q.push_back(mk(S_IDLE, 1'b1, 4'd0, 2'd3, 1'b0, 1'b0));
        tick();
        death_collision = 1'b0;
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin errors++; $display("FAIL idle_ignores_death got=%h exp=%h", got, expv); end
        exp_q.push_back(mk(S_PLAY, 1'b0, 4'd0, 2'd3, 1'b0, 1'b0));
        press_start();
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin errors++; $display("FAIL start_to_play got=%h exp=%h", got, expv); end
    endtask

    task automatic test_death();
        do_reset();
        press_start();
        death_collision = 1'b1;
        frame_tick = 1'b1;   // tick on the entry edge must not count
        exp_q.push_back(mk(S_DEATH, 1'b1, 4'd0, 2'd2, 1'b0, 1'b0));
        tick();
        death_collision = 1'b0; frame_tick = 1'b0;
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin errors++; $display("FAIL death_entry got=%h exp=%h", got, expv); end
        exp_q.push_back(mk(S_DEATH, 1'b1, 4'd0, 2'd2, 1'b0, 1'b0));
        win_collision = 1'b1;
        frames(29);
        win_collision = 1'b0;
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin errors++; $display("FAIL death_freeze_29 got=%h exp=%h", got, expv); end
        exp_q.push_back(mk(S_PLAY, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0));
        frames(1);
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin errors++; $display("FAIL death_freeze_exit got=%h exp=%h", got, expv); end
    endtask

    task automatic test_both_collisions();
        do_reset();
        press_start();
        death_collision = 1'b1; win_collision = 1'b1;
        exp_q.push_back(mk(S_DEATH, 1'b1, 4'd0, 2'd2, 1'b0, 1'b0));
        tick();
        death_collision = 1'b0; win_collision = 1'b0;
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin errors++; $display("FAIL both_death_wins got=%h exp=%h", got, expv); end
        exp_q.push_back(mk(S_PLAY, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0));
        frames(30);
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin errors++; $display("FAIL both_after_freeze got=%h exp=%h", got, expv); end
    endtask

    task automatic test_game_over();
        do_reset();
        press_start();
        for (int d = 0; d < 3; d++) begin
            death_collision = 1'b1;
            tick();
            death_collision = 1'b0;
            frames(30);
        end
        exp_q.push_back(mk(S_OVER, 1'b1, 4'd0, 2'd0, 1'b0, 1'b1));
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin errors++; $display("FAIL game_over_entry got=%h exp=%h", got, expv); end
        death_collision = 1'b1;
        exp_q.push_back(mk(S_OVER, 1'b1, 4'd0, 2'd0, 1'b0, 1'b1));
        frames(5);
        death_collision = 1'b0;
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin errors++; $display("FAIL over_frozen got=%h exp=%h", got, expv); end
        exp_q.push_back(mk(S_PLAY, 1'b0, 4'd0, 2'd3, 1'b0, 1'b0));
        press_start();
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin errors++; $display("FAIL over_restart got=%h exp=%h", got, expv); end
    endtask

    task automatic test_wins();
        logic [3:0] cur, nxt;
        logic [1:0] lv;
        int pulses;
        pulses = 0;
        do_reset();
        press_start();
        death_collision = 1'b1;  // spend a life so the wrap refill is visible
        tick();
        death_collision = 1'b0;
        frames(30);
        for (int i = 0; i < 9; i++) begin
            cur = 4'(i);
            nxt = (i == 8) ? 4'd0 : 4'(i + 1);
            lv  = (i == 8) ? 2'd3 : 2'd2;
            win_collision = 1'b1;
            exp_q.push_back(mk(S_WIN, 1'b1, cur, 2'd2, 1'b0, 1'b0));
            tick();
            win_collision = 1'b0;
            got = obs(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin errors++; $display("FAIL win_entry_%0d got=%h exp=%h", i, got, expv); end
            exp_q.push_back(mk(S_PLAY, 1'b0, nxt, lv, 1'b1, 1'b0));
            frames(30);
            pulses += int'(level_up);
            got = obs(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin errors++; $display("FAIL win_exit_%0d got=%h exp=%h", i, got, expv); end
            exp_q.push_back(mk(S_PLAY, 1'b0, nxt, lv, 1'b0, 1'b0));
            tick();
            got = obs(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin errors++; $display("FAIL level_up_width_%0d got=%h exp=%h", i, got, expv); end
        end
        checks++;
        if (pulses != 9) begin errors++; $display("FAIL level_up_count got=%0d exp=9", pulses); end
    endtask

    task automatic test_reset_mid_freeze();
        do_reset();
        press_start();
        win_collision = 1'b1;
        tick();
        win_collision = 1'b0;
        frames(9);
        reset = 1'b1;
        frame_tick = 1'b1;
        exp_q.push_back(mk(S_IDLE, 1'b1, 4'd0, 2'd3, 1'b0, 1'b0));
        tick();
        reset = 1'b0; frame_tick = 1'b0;
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin errors++; $display("FAIL reset_mid_freeze got=%h exp=%h", got, expv); end
        exp_q.push_back(mk(S_IDLE, 1'b1, 4'd0, 2'd3, 1'b0, 1'b0));
        frames(25);
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin errors++; $display("FAIL idle_after_reset got=%h exp=%h", got, expv); end
    endtask

`ifdef GAME_FLOW_HISCORE_EN
    task automatic test_hiscore();
        logic [3:0] best_exp_q[$];
        logic [3:0] bexp;
        do_reset();
        best_exp_q.push_back(4'd0);
        bexp = best_exp_q.pop_front(); checks++;
        if (best_level !== bexp) begin errors++; $display("FAIL best_reset got=%0d exp=%0d", best_level, bexp); end
        press_start();
        for (int w = 1; w <= 2; w++) begin
            win_collision = 1'b1;
            tick();
            win_collision = 1'b0;
            best_exp_q.push_back(4'(w));
            frames(30);
            bexp = best_exp_q.pop_front(); checks++;
            if (best_level !== bexp) begin errors++; $display("FAIL best_win_%0d got=%0d exp=%0d", w, best_level, bexp); end
        end
        do_reset();
        best_exp_q.push_back(4'd0);
        bexp = best_exp_q.pop_front(); checks++;
        if (best_level !== bexp) begin errors++; $display("FAIL best_cleared got=%0d exp=%0d", best_level, bexp); end
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_death();
        test_both_collisions();
        test_game_over();
        test_wins();
        test_reset_mid_freeze();
`ifdef GAME_FLOW_HISCORE_EN
        test_hiscore();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
